// File: rtl/vx_axi_write_bridge.sv
// Purpose: turns memory-bus write requests into single-beat AXI4 AW+W bursts and returns B as tagged acks.
// Latency: 1 cycle from request accept to awvalid/wvalid; the B path is combinational pass-through.
// Backpressure: request ready needs both slots free (or draining this cycle) and the pending count below its cap.
module vx_axi_write_bridge #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + $clog2(DATA_WIDTH/8),
    parameter int MAX_PENDING    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 mem_req_valid,
    output logic                                 mem_req_ready,
    input  logic [ADDR_WIDTH-1:0]                mem_req_addr,
    input  logic [DATA_WIDTH-1:0]                mem_req_data,
    input  logic [DATA_WIDTH/8-1:0]              mem_req_byteen,
    input  logic [TAG_WIDTH-1:0]                 mem_req_tag,

    output logic                                 mem_rsp_valid,
    input  logic                                 mem_rsp_ready,
    output logic [TAG_WIDTH-1:0]                 mem_rsp_tag,
    output logic                                 mem_rsp_error,

    output logic                                 m_axi_awvalid,
    input  logic                                 m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [TAG_WIDTH-1:0]                 m_axi_awid,
    output logic [7:0]                           m_axi_awlen,
    output logic [2:0]                           m_axi_awsize,
    output logic [1:0]                           m_axi_awburst,
    output logic [1:0]                           m_axi_awlock,
    output logic [3:0]                           m_axi_awcache,
    output logic [2:0]                           m_axi_awprot,
    output logic [3:0]                           m_axi_awqos,
    output logic [3:0]                           m_axi_awregion,

    output logic                                 m_axi_wvalid,
    input  logic                                 m_axi_wready,
    output logic [DATA_WIDTH-1:0]                m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]              m_axi_wstrb,
    output logic                                 m_axi_wlast,

    input  logic                                 m_axi_bvalid,
    output logic                                 m_axi_bready,
    input  logic [TAG_WIDTH-1:0]                 m_axi_bid,
    input  logic [1:0]                           m_axi_bresp,

    output logic [$clog2(MAX_PENDING+1)-1:0]     pending_count,
    output logic                                 idle
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]  id;
    } aw_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [STRB_W-1:0]     strb;
    } w_t;

    logic             aw_vld_q, aw_vld_d;
    aw_t              aw_q, aw_d;
    logic             w_vld_q, w_vld_d;
    w_t               w_q, w_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    logic aw_fire, w_fire, b_fire, accept;

    // Slot next-state, request ready and outstanding-write accounting.
    always_comb begin
        aw_vld_d = aw_vld_q;
        aw_d     = aw_q;
        w_vld_d  = w_vld_q;
        w_d      = w_q;
        pend_d   = pend_q;

        aw_fire = aw_vld_q && m_axi_awready;
        w_fire  = w_vld_q && m_axi_wready;
        b_fire  = m_axi_bvalid && mem_rsp_ready;

        // A slot that drains this cycle can be refilled on the same edge.
        mem_req_ready = (!aw_vld_q || m_axi_awready) &&
                        (!w_vld_q  || m_axi_wready)  &&
                        (pend_q < MAX_CNT);
        accept = mem_req_valid && mem_req_ready;

        if (aw_fire) aw_vld_d = 1'b0;
        if (w_fire)  w_vld_d  = 1'b0;

        if (accept) begin
            aw_vld_d   = 1'b1;
            aw_d.addr  = mem_req_addr;
            aw_d.id    = mem_req_tag;
            w_vld_d    = 1'b1;
            w_d.dat    = mem_req_data;
            w_d.strb   = mem_req_byteen;
        end

        // A stray B with nothing outstanding is ignored so the count never wraps.
        if (accept && !(b_fire && pend_q != '0)) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (!accept && b_fire && pend_q != '0) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    // State registers; reset discards any in-flight writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_vld_q <= 1'b0;
            aw_q     <= '0;
            w_vld_q  <= 1'b0;
            w_q      <= '0;
            pend_q   <= '0;
        end else begin
            aw_vld_q <= aw_vld_d;
            aw_q     <= aw_d;
            w_vld_q  <= w_vld_d;
            w_q      <= w_d;
            pend_q   <= pend_d;
        end
    end

    // B responses are not expected when no write is outstanding.
    b_underflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(m_axi_bvalid && mem_rsp_ready && pend_q == '0));

    assign m_axi_awvalid  = aw_vld_q;
    assign m_axi_awaddr   = AXI_ADDR_WIDTH'({aw_q.addr, {OFF_W{1'b0}}});
    assign m_axi_awid     = aw_q.id;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = 3'(OFF_W);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 2'b00;
    assign m_axi_awcache  = 4'b0000;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awqos    = 4'b0000;
    assign m_axi_awregion = 4'b0000;

    assign m_axi_wvalid   = w_vld_q;
    assign m_axi_wdata    = w_q.dat;
    assign m_axi_wstrb    = w_q.strb;
    assign m_axi_wlast    = 1'b1;

    // Only bresp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign mem_rsp_valid  = m_axi_bvalid;
    assign m_axi_bready   = mem_rsp_ready;
    assign mem_rsp_tag    = m_axi_bid;
    assign mem_rsp_error  = m_axi_bresp[1];

    logic bresp_unused;
    assign bresp_unused   = m_axi_bresp[0];

    assign pending_count  = pend_q;
    assign idle           = (pend_q == '0) && !aw_vld_q && !w_vld_q;

endmodule

// File: tb/tb_vx_axi_write_bridge.sv
// Bench for vx_axi_write_bridge: directed scenarios followed by random traffic.
// Expected values come from a queue-based model of slots and outstanding writes.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
module tb_vx_axi_write_bridge;

    localparam int DW   = 512;
    localparam int AW   = 26;
    localparam int TW   = 8;
    localparam int AXW  = AW + 6;
    localparam int MAXP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic [DW/8-1:0] mem_req_byteen;
    logic [TW-1:0]   mem_req_tag;
    logic            mem_rsp_valid;
    logic            mem_rsp_ready;
    logic [TW-1:0]   mem_rsp_tag;
    logic            mem_rsp_error;
    logic            m_axi_awvalid, m_axi_awready;
    logic [AXW-1:0]  m_axi_awaddr;
    logic [TW-1:0]   m_axi_awid;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst, m_axi_awlock;
    logic [3:0]      m_axi_awcache;
    logic [2:0]      m_axi_awprot;
    logic [3:0]      m_axi_awqos, m_axi_awregion;
    logic            m_axi_wvalid, m_axi_wready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_bvalid, m_axi_bready;
    logic [TW-1:0]   m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic [2:0]      pending_count;
    logic            idle;

    vx_axi_write_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .AXI_ADDR_WIDTH(AXW), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_error(mem_rsp_error),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .pending_count(pending_count), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: writes waiting on each channel, and writes without a B yet.
    logic [AW-1:0]   aq_addr[$];
    logic [TW-1:0]   aq_tag[$];
    logic [DW-1:0]   wq_dat[$];
    logic [DW/8-1:0] wq_strb[$];
    int              pend;
    logic            last_acc;
    int              n_acc;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        aq_addr.delete(); aq_tag.delete(); wq_dat.delete(); wq_strb.delete();
        pend = 0;
    endtask

    task automatic new_req();
        mem_req_addr   = AW'($urandom());
        mem_req_tag    = TW'($urandom());
        mem_req_byteen = {$urandom(), $urandom()};
        for (int k = 0; k < DW / 32; k++) mem_req_data[k*32 +: 32] = $urandom();
    endtask

    // One clock: compare all outputs against the model, then advance the model.
    task automatic cycle();
        logic exp_rdy, acc, awf, wf, bf;
        @(negedge clk);
        exp_rdy = (aq_addr.size() == 0 || m_axi_awready) &&
                  (wq_dat.size() == 0 || m_axi_wready) && (pend < MAXP);
        chk("req_ready", mem_req_ready, exp_rdy);
        chk("awvalid", m_axi_awvalid, aq_addr.size() != 0);
        if (aq_addr.size() != 0) begin
            chk("awaddr", m_axi_awaddr, DW'(aq_addr[0]) * 64);
            chk("awid", m_axi_awid, aq_tag[0]);
        end
        chk("wvalid", m_axi_wvalid, wq_dat.size() != 0);
        if (wq_dat.size() != 0) begin
            chk("wdata", m_axi_wdata, wq_dat[0]);
            chk("wstrb", m_axi_wstrb, wq_strb[0]);
        end
        chk("pending", pending_count, pend);
        chk("idle", idle, pend == 0 && aq_addr.size() == 0 && wq_dat.size() == 0);
        chk("rsp_valid", mem_rsp_valid, m_axi_bvalid);
        chk("bready", m_axi_bready, mem_rsp_ready);
        chk("rsp_tag", mem_rsp_tag, m_axi_bid);
        chk("rsp_err", mem_rsp_error, m_axi_bresp == 2'b10 || m_axi_bresp == 2'b11);

        acc = mem_req_valid && exp_rdy;
        awf = aq_addr.size() != 0 && m_axi_awready;
        wf  = wq_dat.size() != 0 && m_axi_wready;
        bf  = m_axi_bvalid && mem_rsp_ready;
        if (awf) begin void'(aq_addr.pop_front()); void'(aq_tag.pop_front()); end
        if (wf)  begin void'(wq_dat.pop_front());  void'(wq_strb.pop_front()); end
        if (acc) begin
            aq_addr.push_back(mem_req_addr); aq_tag.push_back(mem_req_tag);
            wq_dat.push_back(mem_req_data);  wq_strb.push_back(mem_req_byteen);
            pend++;
            n_acc++;
        end
        if (bf && pend > 0) pend--;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] t2_addr;
    logic [1:0]    t5_resp[4];
    logic          t5_err[4];

    initial begin
        reset = 1'b1;
        mem_req_valid = 0; mem_req_addr = '0; mem_req_data = '0; mem_req_byteen = '0; mem_req_tag = '0;
        mem_rsp_ready = 1; m_axi_awready = 1; m_axi_wready = 1;
        m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = '0;
        model_clear(); last_acc = 0; n_acc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        reset = 1'b0;
        cycle();

        // Constant AW/W fields.
        chk("awlen", m_axi_awlen, 0);
        chk("awsize", m_axi_awsize, 6);
        chk("awburst", m_axi_awburst, 1);
        chk("wlast", m_axi_wlast, 1);
        chk("aw_misc", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion}, 0);

        // Single write.
        new_req();
        mem_req_addr = 26'h10; mem_req_tag = 8'h5A; mem_req_byteen = '1;
        mem_req_valid = 1;
        cycle();
        mem_req_valid = 0;
        chk("t1_awvalid", m_axi_awvalid, 1);
        chk("t1_wvalid", m_axi_wvalid, 1);
        chk("t1_awaddr", m_axi_awaddr, 'h400);
        chk("t1_awid", m_axi_awid, 8'h5A);
        chk("t1_wstrb", m_axi_wstrb, {(DW/8){1'b1}});
        chk("t1_pending", pending_count, 1);
        cycle();
        m_axi_bvalid = 1; m_axi_bid = 8'h5A; m_axi_bresp = 2'b00;
        #1;
        chk("t1_rsp_valid", mem_rsp_valid, 1);
        chk("t1_rsp_tag", mem_rsp_tag, 8'h5A);
        chk("t1_rsp_err", mem_rsp_error, 0);
        cycle();
        m_axi_bvalid = 0;
        #1;
        chk("t1_pending0", pending_count, 0);
        chk("t1_idle", idle, 1);

        // Channel skew: AW stalls three cycles while W drains.
        m_axi_awready = 0; m_axi_wready = 1;
        new_req(); t2_addr = mem_req_addr; mem_req_valid = 1;
        cycle();
        new_req();
        for (int k = 0; k < 3; k++) begin
            chk("t2_ready_stall", mem_req_ready, 0);
            chk("t2_awaddr_hold", m_axi_awaddr, DW'(t2_addr) * 64);
            if (k > 0) chk("t2_w_done", m_axi_wvalid, 0);
            cycle();
        end
        m_axi_awready = 1;
        #1;
        chk("t2_ready_fire", mem_req_ready, 1);
        cycle();
        mem_req_valid = 0;
        cycle();
        m_axi_bvalid = 1; m_axi_bid = TW'($urandom());
        cycle(); cycle();
        m_axi_bvalid = 0;

        // Cap: six back-to-back requests with no B responses.
        n_acc = 0; mem_req_valid = 1; new_req();
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (last_acc) new_req();
        end
        chk("t3_accepts", n_acc, 4);
        chk("t3_pending", pending_count, 4);
        chk("t3_ready_cap", mem_req_ready, 0);
        m_axi_bvalid = 1; m_axi_bid = TW'($urandom());
        cycle();
        m_axi_bvalid = 0;
        #1;
        chk("t3_ready_back", mem_req_ready, 1);
        cycle();
        mem_req_valid = 0;

        // Simultaneous accept and B fire at pending 2.
        m_axi_bvalid = 1;
        cycle(); cycle();
        chk("t4_pre_pending", pending_count, 2);
        new_req(); mem_req_tag = 8'h77; mem_req_valid = 1;
        m_axi_bid = 8'h33; m_axi_bresp = 2'b00;
        #1;
        chk("t4_rsp_tag", mem_rsp_tag, 8'h33);
        cycle();
        mem_req_valid = 0; m_axi_bvalid = 0;
        chk("t4_pending", pending_count, 2);
        chk("t4_awid", m_axi_awid, 8'h77);
        cycle();
        m_axi_bvalid = 1;
        cycle(); cycle();
        m_axi_bvalid = 0;

        // Error mapping, observed without completing a B handshake.
        t5_resp = '{2'b10, 2'b11, 2'b01, 2'b00};
        t5_err  = '{1'b1, 1'b1, 1'b0, 1'b0};
        mem_rsp_ready = 0; m_axi_bvalid = 1;
        for (int k = 0; k < 4; k++) begin
            m_axi_bresp = t5_resp[k];
            #1;
            chk("t5_err", mem_rsp_error, t5_err[k]);
        end
        m_axi_bvalid = 0; mem_rsp_ready = 1; m_axi_bresp = 2'b00;
        cycle();

        // Reset in flight with awvalid=1 and three writes outstanding.
        m_axi_awready = 1; m_axi_wready = 1; mem_req_valid = 1; new_req();
        for (int k = 0; k < 3; k++) begin
            cycle();
            new_req();
        end
        mem_req_valid = 0; m_axi_awready = 0; m_axi_wready = 0;
        chk("t6_pre_awvalid", m_axi_awvalid, 1);
        chk("t6_pre_pending", pending_count, 3);
        #3 reset = 1'b1;
        #1;
        chk("t6_awvalid", m_axi_awvalid, 0);
        chk("t6_wvalid", m_axi_wvalid, 0);
        chk("t6_pending", pending_count, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("t6_idle", idle, 1);
        m_axi_awready = 1; m_axi_wready = 1;
        cycle();

        // Random traffic against the model.
        last_acc = 0;
        for (int i = 0; i < 600; i++) begin
            if (!mem_req_valid || last_acc) begin
                mem_req_valid = ($urandom_range(0, 3) != 0);
                new_req();
            end
            m_axi_awready = ($urandom_range(0, 3) != 0);
            m_axi_wready  = ($urandom_range(0, 3) != 0);
            m_axi_bvalid  = ($urandom_range(0, 2) == 0);
            m_axi_bid     = TW'($urandom());
            m_axi_bresp   = 2'($urandom());
            mem_rsp_ready = (pend > 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
